// File: rtl/addr_dec_seq.sv
// Descending address sequencer for NTRU-HRSS coefficient walks, using a handshake on addr_valid/addr_ready.
// Define DEC_WRAP_EN for cyclic mode: a count port, modulo-N decrement, and a final transfer chosen by count.
module addr_dec_seq #(
    parameter int WIDTH = 10,
    parameter int N     = 701
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] start_val,
`ifdef DEC_WRAP_EN
    input  logic [WIDTH:0]   count,
`endif
    output logic [WIDTH-1:0] addr,
    output logic             addr_valid,
    input  logic             addr_ready,
    output logic             busy,
    output logic             done
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(N - 1);
    localparam int               LVLS = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] addr_q, addr_d;
`ifdef DEC_WRAP_EN
    logic [WIDTH:0]   rem_q, rem_d;
`endif

    // Bit i of a-1 flips exactly when a[i-1:0] is all zero; the Sklansky tree supplies those prefix ORs.
    function automatic logic [WIDTH-1:0] dec_prefix(input logic [WIDTH-1:0] a);
        logic [WIDTH-1:0] p;
        logic [WIDTH-1:0] nxt;
        logic [WIDTH-1:0] r;
        p = a;
        for (int l = 0; l < LVLS; l++) begin
            nxt = p;
            for (int i = 0; i < WIDTH; i++) begin
                if (((i >> l) & 1) == 1) begin
                    nxt[i] = p[i] | p[((i >> l) << l) - 1];
                end
            end
            p = nxt;
        end
        r[0] = ~a[0];
        for (int i = 1; i < WIDTH; i++) begin
            r[i] = a[i] ^ ~p[i-1];
        end
        return r;
    endfunction

    function automatic logic [WIDTH-1:0] clamp_addr(input logic [WIDTH-1:0] v);
        return (v > LAST) ? LAST : v;
    endfunction

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
`ifdef DEC_WRAP_EN
        rem_d   = rem_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d = clamp_addr(start_val);
`ifdef DEC_WRAP_EN
                    rem_d   = count;
                    state_d = (count == '0) ? DONE : RUN;
`else
                    state_d = RUN;
`endif
                end
            end
            RUN: begin
                if (addr_ready) begin
`ifdef DEC_WRAP_EN
                    rem_d = rem_q - (WIDTH+1)'(1);
                    if (rem_q == (WIDTH+1)'(1)) begin
                        state_d = DONE;
                    end else begin
                        addr_d = (addr_q == '0) ? LAST : dec_prefix(addr_q);
                    end
`else
                    if (addr_q == '0) begin
                        state_d = DONE;
                    end else begin
                        addr_d = dec_prefix(addr_q);
                    end
`endif
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
`ifdef DEC_WRAP_EN
            rem_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
`ifdef DEC_WRAP_EN
            rem_q   <= rem_d;
`endif
        end
    end

    // Status outputs decode the state register, so reset clears them without waiting for a clock edge.
    assign addr       = addr_q;
    assign addr_valid = (state_q == RUN);
    assign busy       = (state_q == RUN);
    assign done       = (state_q == DONE);

endmodule

// File: doc/addr_dec_seq.md
ADDR_DEC_SEQ -- requirements
Module: addr_dec_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 10: address width in bits.
REQ-002 SHALL have parameter N, default 701: ring length (NTRU-HRSS coefficient count); legal addresses 0..N-1, N <= 2^WIDTH.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port start, input, 1: one-cycle request to begin a sequence; honoured only in IDLE.
REQ-006 SHALL have port start_val, input, WIDTH: first address issued; sampled with start.
REQ-007 SHALL have port addr, output, WIDTH: current address.
REQ-008 SHALL have port addr_valid, output, 1: addr is valid.
REQ-009 SHALL have port addr_ready, input, 1: consumer accepts addr this cycle.
REQ-010 SHALL have port busy, output, 1: high in RUN.
REQ-011 SHALL have port done, output, 1: one-cycle pulse after the last accepted address.
REQ-012 SHALL have port count, input, WIDTH+1: number of addresses to issue; present only when DEC_WRAP_EN is defined.

Function
REQ-013 SHALL implement states IDLE, RUN, DONE.
REQ-014 SHALL, in IDLE with start=1, load addr<=start_val and go to RUN next cycle; start_val >= N is clamped to N-1.
REQ-015 SHALL hold addr_valid=1 throughout RUN and 0 in IDLE and DONE.
REQ-016 SHALL count a transfer only on a cycle with addr_valid=1 and addr_ready=1; addr SHALL stay stable while addr_valid=1 and addr_ready=0.
REQ-017 SHALL, on each non-final transfer, update addr to addr-1, computed by a parallel-prefix (Sklansky OR-prefix borrow) decrementer, not a ripple chain.
REQ-018 SHALL, without DEC_WRAP_EN, treat the transfer with addr=0 as final; sequence length is start_val+1.
REQ-019 SHALL, on the final transfer, go to DONE; DONE SHALL assert done=1 for exactly one cycle and return to IDLE next cycle.
REQ-020 SHALL ignore start in RUN and DONE; start in the cycle done is high SHALL be ignored.
REQ-021 SHALL accept a new start in the first IDLE cycle after DONE (back-to-back sequences, one idle cycle gap).
REQ-022 SHALL keep addr holding its last value in DONE and IDLE.

Reset
REQ-023 SHALL, on rst_n=0, asynchronously force state=IDLE, addr=0, addr_valid=0, busy=0, done=0, internal remaining-count=0.
REQ-024 SHALL, when reset asserts mid-sequence, abandon the sequence with no done pulse; after rst_n rises, only a new start resumes activity.

Configuration
REQ-025 SHALL use macro DEC_WRAP_EN to enable cyclic mode.
REQ-026 SHALL, with DEC_WRAP_EN, sample count with start, decrement addr modulo N (0 -> N-1), and treat the count-th transfer as final regardless of addr; count=0 SHALL go directly IDLE -> DONE (done pulse, no addr_valid).
REQ-027 SHALL, without DEC_WRAP_EN, have no count port and no remaining-count register; behaviour per REQ-018.

Verification
REQ-028 SHALL cover: start, start_val=5, addr_ready=1 constant -> addr 5,4,3,2,1,0 on consecutive RUN cycles, done one cycle after the addr=0 transfer.
REQ-029 SHALL cover: start_val=3, addr_ready toggling 1,0,0,1,... -> addr held during stall cycles, sequence 3,2,1,0 unchanged, exactly 4 transfers.
REQ-030 SHALL cover: start_val=700 vs 800 -> both begin at 700; start_val=0 -> single transfer then done.
REQ-031 SHALL cover: rst_n pulsed low while addr=350 in RUN -> outputs zero immediately, no done, later start_val=2 runs 2,1,0.
REQ-032 SHALL cover (DEC_WRAP_EN): start_val=1, count=4 -> addr 1,0,700,699 then done; count=0 -> done pulse with no addr_valid.
REQ-033 SHALL cover: start asserted during RUN and in the done cycle -> ignored; start on next IDLE cycle -> new sequence begins.
